// File: rtl/fixed_point_add_tree.sv
// rtl/fixed_point_add_tree.sv - pipelined multi-operand signed fixed-point adder tree
module fixed_point_add_tree #(
  parameter int WIDTH      = 8,
  parameter int FRAC_BITS  = 3,
  parameter int NUM_INPUTS = 4,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                        CLK,
  input  logic                        RSTN,
  input  logic [NUM_INPUTS*WIDTH-1:0] VALUES_IN,
  input  logic                        VALID_IN,
  input  logic                        OVERFLOW_CLR,
  output logic [WIDTH-1:0]            VALUE_OUT,
  output logic                        VALID_OUT,
  output logic                        OVERFLOW,
  output logic                        OVERFLOW_STICKY
);

  // Tree depth, padded leaf count and the exact width of the full sum.
  localparam int LEVELS = $clog2(NUM_INPUTS);
  localparam int LEAVES = 1 << LEVELS;
  localparam int TW     = WIDTH + LEVELS;

  // The binary point is shared by every operand and the result, so it only
  // constrains legal configurations and never shifts any data.
  if (FRAC_BITS < 1 || NUM_INPUTS < 2 || WIDTH < 2) begin : g_param_check
    $error("fixed_point_add_tree: needs FRAC_BITS >= 1, NUM_INPUTS >= 2, WIDTH >= 2");
  end

  // Leaves are the sign-extended operands; padding leaves are zero.
  logic signed [TW-1:0] leaf [LEAVES];

  for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
    if (i < NUM_INPUTS) begin : g_op
      assign leaf[i] = {{LEVELS{VALUES_IN[i*WIDTH+WIDTH-1]}}, VALUES_IN[i*WIDTH +: WIDTH]};
    end else begin : g_pad
      assign leaf[i] = '0;
    end
  end

  // vld_chain[k] is the valid bit feeding tree level k+1; index 0 is the input.
  logic [LEVELS-1:0] vld_q;
  logic [LEVELS:0]   vld_chain;

  assign vld_chain = {vld_q, VALID_IN};

  // Shift the valid bit alongside the data through every tree level.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_chain[LEVELS-1:0];
    end
  end

  // Heap-ordered internal nodes: node 1 is the root, node n has children 2n
  // and 2n+1, and children at index LEAVES or above are the operand leaves.
  // Every node is carried at the final width so no level can overflow.
  logic signed [TW-1:0] sum_q [1:LEAVES-1];

  for (genvar n = 1; n < LEAVES; n++) begin : g_node
    localparam int DEPTH = $clog2(n + 1) - 1;
    localparam int LVL   = LEVELS - DEPTH;

    logic signed [TW-1:0] lhs;
    logic signed [TW-1:0] rhs;

    if (2 * n >= LEAVES) begin : g_from_leaf
      assign lhs = leaf[2*n - LEAVES];
      assign rhs = leaf[2*n + 1 - LEAVES];
    end else begin : g_from_node
      assign lhs = sum_q[2*n];
      assign rhs = sum_q[2*n + 1];
    end

    // Register this node's pair sum only when its level carries a valid vector.
    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
        sum_q[n] <= '0;
      end else if (vld_chain[LVL-1]) begin
        sum_q[n] <= lhs + rhs;
      end
    end
  end

  // The full sum fits WIDTH bits only when its top LEVELS+1 bits all match.
  logic signed [TW-1:0] root;
  logic [LEVELS:0]      top_bits;
  logic                 range_ovf;
  logic [WIDTH-1:0]     result;

  assign root      = sum_q[1];
  assign top_bits  = root[TW-1:WIDTH-1];
  assign range_ovf = (top_bits != '0) && (top_bits != '1);

  // Clamp toward the sign of the full sum, or keep the low WIDTH bits.
  always_comb begin
    result = root[WIDTH-1:0];
    if (SATURATE && range_ovf) begin
      result = root[TW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  // Output register: strobe, per-result overflow and a held result value.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      VALID_OUT <= 1'b0;
      OVERFLOW  <= 1'b0;
      VALUE_OUT <= '0;
    end else begin
      VALID_OUT <= vld_chain[LEVELS];
      OVERFLOW  <= vld_chain[LEVELS] & range_ovf;
      if (vld_chain[LEVELS]) begin
        VALUE_OUT <= result;
      end
    end
  end

  // Sticky overflow: a qualified overflow pulse takes priority over a clear.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      OVERFLOW_STICKY <= 1'b0;
    end else if (VALID_OUT && OVERFLOW) begin
      OVERFLOW_STICKY <= 1'b1;
    end else if (OVERFLOW_CLR) begin
      OVERFLOW_STICKY <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fixed_point_add_tree.sv
// tb/tb_fixed_point_add_tree.sv - self-checking bench for fixed_point_add_tree
module tb_fixed_point_add_tree;

  localparam int W   = 8;
  localparam int N   = 4;
  localparam int LAT = 3;

  logic         CLK = 1'b0;
  logic         RSTN = 1'b0;
  logic [N*W-1:0] VALUES_IN = '0;
  logic         VALID_IN = 1'b0;
  logic         OVERFLOW_CLR = 1'b0;

  logic [W-1:0] s_value, w_value;
  logic         s_valid, w_valid, s_ovf, w_ovf, s_sticky, w_sticky;

  fixed_point_add_tree #(.WIDTH(W), .FRAC_BITS(3), .NUM_INPUTS(N), .SATURATE(1'b1)) u_sat (
    .CLK(CLK), .RSTN(RSTN), .VALUES_IN(VALUES_IN), .VALID_IN(VALID_IN),
    .OVERFLOW_CLR(OVERFLOW_CLR), .VALUE_OUT(s_value), .VALID_OUT(s_valid),
    .OVERFLOW(s_ovf), .OVERFLOW_STICKY(s_sticky)
  );

  fixed_point_add_tree #(.WIDTH(W), .FRAC_BITS(3), .NUM_INPUTS(N), .SATURATE(1'b0)) u_wrap (
    .CLK(CLK), .RSTN(RSTN), .VALUES_IN(VALUES_IN), .VALID_IN(VALID_IN),
    .OVERFLOW_CLR(OVERFLOW_CLR), .VALUE_OUT(w_value), .VALID_OUT(w_valid),
    .OVERFLOW(w_ovf), .OVERFLOW_STICKY(w_sticky)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [7:0] sat_v;
    logic [7:0] wrap_v;
    bit         ovf;
  } exp_t;

  exp_t q[$];
  bit   m_sticky = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer sum, then range check, clamp or wrap.
  function automatic void model(input logic [N*W-1:0] v, output logic [7:0] sv,
                                output logic [7:0] wv, output bit ovf);
    int s;
    logic signed [W-1:0] op;
    s = 0;
    for (int i = 0; i < N; i++) begin
      op = v[i*W +: W];
      s += int'(op);
    end
    ovf = (s > 127) || (s < -128);
    wv  = s[7:0];
    if (!ovf)      sv = s[7:0];
    else if (s > 0) sv = 8'h7F;
    else           sv = 8'h80;
  endfunction

  // Compare process: every cycle, both DUTs against the queued expectations.
  always @(negedge CLK) begin
    exp_t e;
    exp_t n;
    bit   due_now;
    if (!RSTN) begin
      check("rst_sat_value", s_value, 0);
      check("rst_sat_valid", s_valid, 0);
      check("rst_sat_ovf", s_ovf, 0);
      check("rst_sat_sticky", s_sticky, 0);
      check("rst_wrap_value", w_value, 0);
      check("rst_wrap_valid", w_valid, 0);
      check("rst_wrap_ovf", w_ovf, 0);
      check("rst_wrap_sticky", w_sticky, 0);
      q.delete();
      m_sticky = 1'b0;
    end else begin
      due_now = (q.size() > 0) && (q[0].due == cyc);
      check("sat_valid", s_valid, due_now);
      check("wrap_valid", w_valid, due_now);
      if (due_now) begin
        e = q.pop_front();
        check("sat_value", s_value, e.sat_v);
        check("wrap_value", w_value, e.wrap_v);
        check("sat_ovf", s_ovf, e.ovf);
        check("wrap_ovf", w_ovf, e.ovf);
      end else begin
        e.ovf = 1'b0;
        check("sat_ovf_idle", s_ovf, 0);
        check("wrap_ovf_idle", w_ovf, 0);
      end
      check("sat_sticky", s_sticky, m_sticky);
      check("wrap_sticky", w_sticky, m_sticky);
      if (due_now && e.ovf) m_sticky = 1'b1;
      else if (OVERFLOW_CLR) m_sticky = 1'b0;
      if (VALID_IN) begin
        n.due = cyc + LAT;
        model(VALUES_IN, n.sat_v, n.wrap_v, n.ovf);
        q.push_back(n);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One vector, then hand-computed literals exactly LAT cycles later.
  task automatic send_and_check(input string name, input logic [31:0] vec,
                                input logic [7:0] es, input logic [7:0] ew,
                                input bit eo, input bit clr_at_out);
    VALUES_IN = vec;
    VALID_IN  = 1'b1;
    step();
    VALID_IN  = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    OVERFLOW_CLR = clr_at_out;
    @(negedge CLK);
    check({name, "_lit_valid"}, s_valid, 1);
    check({name, "_lit_sat"}, s_value, es);
    check({name, "_lit_wrap"}, w_value, ew);
    check({name, "_lit_ovf"}, s_ovf, eo);
    step();
    OVERFLOW_CLR = 1'b0;
    if (eo) check({name, "_lit_sticky"}, s_sticky, 1);
  endtask

  function automatic logic [7:0] rand_op();
    logic [7:0] x;
    logic [7:0] ext [4];
    ext[0] = 8'h7F; ext[1] = 8'h80; ext[2] = 8'h81; ext[3] = 8'h00;
    case ($urandom_range(0, 2))
      0:       x = 8'($urandom);
      1:       x = 8'($urandom_range(0, 31) - 16);
      default: x = ext[$urandom_range(0, 3)];
    endcase
    return x;
  endfunction

  function automatic logic [N*W-1:0] rand_vec();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = rand_op();
    return v;
  endfunction

  initial begin
    RSTN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RSTN = 1'b1;
    step();

    send_and_check("basic", 32'h0808_0808, 8'h20, 8'h20, 1'b0, 1'b0);
    send_and_check("pos_ovf", 32'h7F7F_7F7F, 8'h7F, 8'hFC, 1'b1, 1'b0);
    send_and_check("neg_ovf", 32'h8080_8080, 8'h80, 8'h00, 1'b1, 1'b0);

    OVERFLOW_CLR = 1'b1;
    step();
    OVERFLOW_CLR = 1'b0;
    check("clr_sticky", s_sticky, 0);

    send_and_check("excursion", 32'h8181_7F7F, 8'h00, 8'h00, 1'b0, 1'b0);
    send_and_check("clr_collide", 32'h7F7F_7F7F, 8'h7F, 8'hFC, 1'b1, 1'b1);

    OVERFLOW_CLR = 1'b1;
    step();
    OVERFLOW_CLR = 1'b0;
    check("clr_alone_sticky", w_sticky, 0);

    // Five back-to-back vectors, one idle cycle, one more vector.
    for (int i = 0; i < 5; i++) begin
      VALUES_IN = rand_vec();
      VALID_IN  = 1'b1;
      step();
    end
    VALID_IN = 1'b0;
    step();
    VALUES_IN = rand_vec();
    VALID_IN  = 1'b1;
    step();
    VALID_IN = 1'b0;
    repeat (6) step();

    // Random traffic with occasional sticky clears.
    for (int i = 0; i < 400; i++) begin
      VALUES_IN    = rand_vec();
      VALID_IN     = ($urandom_range(0, 9) < 7);
      OVERFLOW_CLR = ($urandom_range(0, 15) == 0);
      step();
    end
    VALID_IN     = 1'b0;
    OVERFLOW_CLR = 1'b0;
    repeat (6) step();

    // Reset with two vectors in flight after an overflow has set the sticky.
    send_and_check("pre_rst", 32'h7F7F_7F7F, 8'h7F, 8'hFC, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      VALUES_IN = rand_vec();
      VALID_IN  = 1'b1;
      step();
    end
    VALID_IN = 1'b0;
    RSTN = 1'b0;
    #1;
    check("rst_now_sat_value", s_value, 0);
    check("rst_now_wrap_value", w_value, 0);
    check("rst_now_sticky", s_sticky, 0);
    check("rst_now_valid", s_valid, 0);
    step();
    RSTN = 1'b1;
    repeat (8) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fixed_point_add_tree.md
Name: fixed_point_add_tree

Overview:
Parametrised, pipelined multi-operand fixed-point adder. It sums NUM_INPUTS signed operands through a registered binary adder tree and produces one WIDTH-bit result per accepted input vector. Optional saturation, a per-result overflow flag and a sticky overflow flag are provided. It sits in datapaths that reduce several channels at once, such as dot-product and MAC reduction stages, where a single two-operand adder is not enough.

Parameters:
WIDTH, 8, operand and result width in bits (two's complement).
FRAC_BITS, 3, fractional bits. Must be strictly positive. Shared by all operands and the result, so no alignment shift is needed.
NUM_INPUTS, 4, number of operands. Must be at least 2. Non-power-of-2 values are legal; missing tree leaves are zero-padded.
SATURATE, 1, 1 = clamp the result on overflow; 0 = wrap the result to its low WIDTH bits.

Ports:
CLK  in  1  clock, rising edge.
RSTN  in  1  asynchronous active-low reset.
VALUES_IN  in  NUM_INPUTS*WIDTH  packed operands. Operand i occupies bits [i*WIDTH +: WIDTH].
VALID_IN  in  1  qualifies VALUES_IN in the current cycle.
OVERFLOW_CLR  in  1  synchronous clear of OVERFLOW_STICKY.
VALUE_OUT  out  WIDTH  signed sum, saturated or wrapped.
VALID_OUT  out  1  one-cycle strobe that qualifies VALUE_OUT and OVERFLOW.
OVERFLOW  out  1  the current result overflowed the WIDTH range. Qualified by VALID_OUT.
OVERFLOW_STICKY  out  1  latched OR of all qualified OVERFLOW pulses since the last clear or reset.

Behaviour:
- Reset (RSTN low, asynchronous): every pipeline register, VALUE_OUT, VALID_OUT, OVERFLOW and OVERFLOW_STICKY go to 0. All in-flight data is discarded and no VALID_OUT is issued for it after release.
- LEVELS = ceil(log2(NUM_INPUTS)).
- Tree level k adds operand pairs with sign extension by one bit. Final internal width is WIDTH+LEVELS, which is exact, so the tree never overflows internally.
- Each tree level is registered, followed by one output register that performs saturate or wrap.
- Latency is LEVELS+1 cycles from VALID_IN to VALID_OUT. Example: NUM_INPUTS=4 gives 3 cycles.
- Throughput is one vector per cycle. There is no backpressure; the block always accepts input.
- A valid bit shifts alongside the data stages. Data registers load only when their stage valid is 1; otherwise they hold their value.
- VALID_OUT is high for exactly one cycle per accepted vector. Results leave in input order.
- Range check on the full sum S: overflow = (S > 2^(WIDTH-1)-1) or (S < -2^(WIDTH-1)).
- SATURATE=1: on a positive overflow VALUE_OUT = 2^(WIDTH-1)-1; on a negative overflow VALUE_OUT = -2^(WIDTH-1).
- SATURATE=0: VALUE_OUT = S[WIDTH-1:0].
- OVERFLOW is registered alongside VALUE_OUT. It is 0 in any cycle where VALID_OUT is 0.
- OVERFLOW_STICKY is set on any cycle with VALID_OUT=1 and OVERFLOW=1, and cleared when OVERFLOW_CLR=1. If set and clear occur in the same cycle, set wins.
- VALUE_OUT holds its last value between valid strobes.
- Zero-padded leaves contribute 0 and do not change the range check.

Test Plan:
Config WIDTH=8, FRAC_BITS=3, NUM_INPUTS=4, so representable values are -16.0 to +15.875 and latency is 3 cycles.
1. Basic sum: operands {0x08,0x08,0x08,0x08} (4 x 1.0) with one VALID_IN pulse -> VALID_OUT pulses exactly 3 cycles later; VALUE_OUT=0x20 (4.0), OVERFLOW=0.
2. Saturate, SATURATE=1: operands {0x7F x4} -> VALUE_OUT=0x7F, OVERFLOW=1, OVERFLOW_STICKY=1. Operands {0x80 x4} -> VALUE_OUT=0x80, OVERFLOW=1.
3. Wrap, SATURATE=0: operands {0x7F x4} (sum 508) -> VALUE_OUT=0xFC, OVERFLOW=1. Operands {0x80 x4} -> VALUE_OUT=0x00, OVERFLOW=1.
4. Partial-sum excursion: operands {0x7F,0x7F,0x81,0x81} -> VALUE_OUT=0x00, OVERFLOW=0. The exact internal width must prevent any false overflow.
5. Streaming and ordering: 5 back-to-back valid vectors, then 1 idle cycle, then 1 more vector -> VALID_OUT high for 5 consecutive cycles, one cycle low, then 1 pulse, with results in order. Randomised vectors must match a reference model.
6. Sticky and reset: drive an overflowing vector so its OVERFLOW pulse coincides with OVERFLOW_CLR=1 -> OVERFLOW_STICKY=1. Then OVERFLOW_CLR alone -> OVERFLOW_STICKY=0. Assert RSTN low for one cycle while 2 vectors are in flight -> all outputs are 0 immediately and no VALID_OUT appears afterwards.
